// File: rtl/conv_result_writer.sv
// rtl/conv_result_writer.sv - captures convolution results in a FIFO and drains them to the output pixel RAM
// Optional feature macro: CONV_WRITER_RELU_EN (clamp negative results to zero before buffering).
module conv_result_writer #(
   parameter int n     = 8,
   parameter int m     = 6,
   parameter int p     = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     donemult,
   input  logic [n-1:0]             result,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic                     wr_outram,
   output logic [m-1:0]             outadr,
   output logic [n-1:0]             dataout,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int NPIX = (p - 2) * (p - 2);
   localparam logic [m:0]    NPIX_C = (m+1)'(NPIX);
   localparam logic [LW-1:0] FULL_C = LW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [n-1:0]    r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [LW-1:0]   r_level;
   logic [m:0]      r_wr_cnt;
   logic [m:0]      r_cap_cnt;
   logic            r_busy;
   logic            r_frame_done;
   logic            r_overflow;

   logic            w_pop;
   logic            w_cap_ok;
   logic            w_push;
   logic            w_drop;
   logic            w_last;
   logic [n-1:0]    w_cap_data;
   logic [AW-1:0]   w_wr_idx;

`ifdef CONV_WRITER_RELU_EN
   assign w_cap_data = result[n-1] ? '0 : result;
`else
   assign w_cap_data = result;
`endif

   assign wr_valid   = (r_level != '0);
   assign wr_outram  = wr_valid & wr_ready;
   assign dataout    = wr_valid ? r_mem[r_rptr] : '0;
   assign outadr     = r_wr_cnt[m-1:0];
   assign level      = r_level;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

   assign w_pop    = wr_outram;
   assign w_cap_ok = (r_state == S_RUN) && donemult && (r_cap_cnt < NPIX_C);
   // A start-cycle result becomes entry 0 of the freshly emptied FIFO.
   assign w_push   = start ? donemult : (w_cap_ok && ((r_level != FULL_C) || w_pop));
   assign w_drop   = !start && w_cap_ok && (r_level == FULL_C) && !w_pop;
   assign w_last   = w_pop && (r_wr_cnt == NPIX_C - 1'b1);
   assign w_wr_idx = start ? '0 : r_wptr;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[w_wr_idx] <= w_cap_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_level      <= '0;
         r_wr_cnt     <= '0;
         r_cap_cnt    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else if (start) begin
         r_state      <= S_RUN;
         r_busy       <= 1'b1;
         r_wptr       <= AW'(donemult);
         r_rptr       <= '0;
         r_level      <= LW'(donemult);
         r_wr_cnt     <= '0;
         r_cap_cnt    <= (m+1)'(donemult);
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr    <= r_wptr + 1'b1;
            r_cap_cnt <= r_cap_cnt + 1'b1;
         end
         if (w_pop) begin
            r_rptr   <= r_rptr + 1'b1;
            r_wr_cnt <= r_wr_cnt + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_drop) r_overflow <= 1'b1;
         if (w_last) begin
            r_state      <= S_DONE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv_result_writer.sv
// tb/tb_conv_result_writer.sv - directed bench for conv_result_writer with a queue-based reference model
module tb_conv_result_writer;
   localparam int N = 8, M = 6, P = 5, DEPTH = 4, NPIX = 9;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         donemult = 1'b0;
   logic [N-1:0] result = '0;
   logic         wr_ready = 1'b0;
   logic         wr_valid, wr_outram, busy, frame_done, overflow;
   logic [M-1:0] outadr;
   logic [N-1:0] dataout;
   logic [2:0]   level;

   conv_result_writer #(.n(N), .m(M), .p(P), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .donemult(donemult), .result(result),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_outram(wr_outram),
      .outadr(outadr), .dataout(dataout), .busy(busy), .frame_done(frame_done),
      .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO is a queue, the frame is a count of writes.
   logic [N-1:0] m_q[$];
   int           m_wcnt = 0, m_ccnt = 0;
   bit           m_run = 0, m_fd = 0, m_ovf = 0;
   int           msz;
   bit           mpop, mrun0;

   logic [N-1:0] log_d[$];
   logic [M-1:0] log_a[$];

   bit           prev_stall = 0;
   logic [N-1:0] prev_data;
   logic [M-1:0] prev_adr;

   function automatic logic [N-1:0] relu(input logic [N-1:0] v);
`ifdef CONV_WRITER_RELU_EN
      return v[N-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         m_q.delete();
         m_wcnt = 0; m_ccnt = 0; m_run = 0; m_fd = 0; m_ovf = 0;
         prev_stall = 0;
      end
      chk("wr_valid",   wr_valid,   m_q.size() != 0);
      chk("wr_outram",  wr_outram,  (m_q.size() != 0) && wr_ready);
      chk("dataout",    dataout,    (m_q.size() != 0) ? m_q[0] : 8'h00);
      chk("outadr",     outadr,     m_wcnt);
      chk("level",      level,      m_q.size());
      chk("busy",       busy,       m_run);
      chk("frame_done", frame_done, m_fd);
      chk("overflow",   overflow,   m_ovf);
      if (prev_stall && wr_valid) begin
         chk("stall_data", dataout, prev_data);
         chk("stall_adr",  outadr,  prev_adr);
      end
      prev_stall = rst && wr_valid && !wr_ready && !start;
      prev_data  = dataout;
      prev_adr   = outadr;
      if (rst && wr_outram) begin
         log_d.push_back(dataout);
         log_a.push_back(outadr);
      end
      // Advance the model with the inputs the next rising edge will sample.
      if (rst) begin
         msz   = m_q.size();
         mpop  = (msz != 0) && wr_ready;
         mrun0 = m_run;
         if (start) begin
            m_q.delete();
            if (donemult) m_q.push_back(relu(result));
            m_wcnt = 0; m_ccnt = donemult ? 1 : 0;
            m_run = 1; m_fd = 0; m_ovf = 0;
         end else begin
            if (mpop) begin
               void'(m_q.pop_front());
               m_wcnt++;
               if (m_wcnt == NPIX) begin m_run = 0; m_fd = 1; end
            end
            if (mrun0 && donemult && m_ccnt < NPIX) begin
               if (msz < DEPTH || mpop) begin
                  m_q.push_back(relu(result));
                  m_ccnt++;
               end else m_ovf = 1;
            end
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic do_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic push(input logic [N-1:0] v, input int gap);
      donemult = 1'b1; result = v; cyc(1); donemult = 1'b0; cyc(gap);
   endtask

   task automatic clear_log();
      log_d.delete(); log_a.delete();
   endtask

   task automatic check_seq(input string nm, input int first, input int cnt);
      chk({nm, "_count"}, log_d.size(), cnt);
      for (int i = 0; i < cnt && i < log_d.size(); i++) begin
         chk({nm, "_adr"},  log_a[i], i);
         chk({nm, "_data"}, log_d[i], first + i);
      end
   endtask

   initial begin
      int idx;
      logic [N-1:0] exp_relu [4];
      cyc(3);
      chk("rst_valid", wr_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_adr", outadr, 0);
      rst = 1'b1;
      cyc(2);

      // Nine spaced results, RAM always ready.
      clear_log(); wr_ready = 1'b1;
      do_start();
      for (int v = 1; v <= 9; v++) push(N'(v), 2);
      cyc(3);
      check_seq("frame1", 1, 9);
      chk("frame1_done", frame_done, 1);
      chk("frame1_busy", busy, 0);

      // Overflow with RAM stalled; first result arrives with start.
      clear_log(); wr_ready = 1'b0;
      start = 1'b1; donemult = 1'b1; result = 8'd10; cyc(1); start = 1'b0;
      for (int v = 11; v <= 14; v++) begin result = N'(v); cyc(1); end
      donemult = 1'b0;
      chk("ovf_level", level, 4);
      chk("ovf_flag", overflow, 1);
      wr_ready = 1'b1; cyc(6);
      check_seq("ovf", 10, 4);
      chk("ovf_level0", level, 0);

      // Full FIFO with simultaneous push and pop.
      clear_log(); wr_ready = 1'b0;
      do_start();
      for (int v = 20; v <= 23; v++) push(N'(v), 0);
      chk("full_level", level, 4);
      wr_ready = 1'b1; donemult = 1'b1; result = 8'd24; cyc(1); donemult = 1'b0;
      chk("pp_level", level, 4);
      chk("pp_ovf", overflow, 0);
      cyc(6);
      check_seq("pp", 20, 5);

      // Ready toggling every cycle.
      clear_log();
      do_start();
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         wr_ready = (c % 2) == 1;
         donemult = (c % 3 == 0) && (idx < 9);
         result = N'(30 + idx);
         cyc(1);
         if (donemult) idx++;
      end
      donemult = 1'b0; wr_ready = 1'b1; cyc(3);
      check_seq("toggle", 30, 9);
      chk("toggle_done", frame_done, 1);

      // Reset mid-frame after four writes.
      clear_log(); wr_ready = 1'b1;
      do_start();
      for (int v = 40; v <= 43; v++) push(N'(v), 2);
      chk("mid_count", log_d.size(), 4);
      push(8'd44, 0);
      chk("mid_pending", wr_valid, 1);
      rst = 1'b0; #1;
      chk("mid_rst_valid", wr_valid, 0);
      chk("mid_rst_strobe", wr_outram, 0);
      chk("mid_rst_level", level, 0);
      chk("mid_rst_data", dataout, 0);
      chk("mid_rst_adr", outadr, 0);
      chk("mid_rst_busy", busy, 0);
      push(8'd46, 1);
      rst = 1'b1;
      push(8'd47, 2);
      chk("idle_level", level, 0);
      chk("idle_count", log_d.size(), 4);
      clear_log();
      do_start();
      push(8'd50, 2);
      push(8'd51, 2);
      check_seq("restart", 50, 2);

      // Sign handling of the captured value.
      clear_log();
`ifdef CONV_WRITER_RELU_EN
      exp_relu = '{8'h00, 8'h05, 8'h00, 8'h7F};
`else
      exp_relu = '{8'hF6, 8'h05, 8'h80, 8'h7F};
`endif
      do_start();
      push(8'hF6, 2); push(8'h05, 2); push(8'h80, 2); push(8'h7F, 2);
      chk("relu_count", log_d.size(), 4);
      for (int i = 0; i < 4 && i < log_d.size(); i++) begin
         chk("relu_data", log_d[i], exp_relu[i]);
         chk("relu_adr", log_a[i], i);
      end

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
